// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor controller.
// State encodings and the counter-width helper.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Request/result bundle of the bit-serial subtractor.
// zero/ovf exist only when SUB_FLAGS_EN is defined.
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             bin_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dif_out;
    logic             bout;
`ifdef SUB_FLAGS_EN
    logic             zero;
    logic             ovf;
`endif

    modport master (
        output start, a_in, b_in, bin_in,
`ifdef SUB_FLAGS_EN
        input  zero, ovf,
`endif
        input  busy, done, dif_out, bout
    );

    modport slave (
        input  start, a_in, b_in, bin_in,
`ifdef SUB_FLAGS_EN
        output zero, ovf,
`endif
        output busy, done, dif_out, bout
    );
endinterface

// File: rtl/full_sub_cell.sv
// One-bit full subtractor reused once per clock.
// d = a - b - br, bo is the borrow out of this bit.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic dif,
    output logic bout
);
    assign dif  = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial N-bit subtractor controller, LSB first, one bit per clock.
// Optional zero/ovf flags are enabled by defining SUB_FLAGS_EN.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_sub_ctrl_if.slave  bus
);
    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] dif_q, dif_d;
    logic             bout_q, bout_d;
`ifdef SUB_FLAGS_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
`endif

    logic cell_d;
    logic cell_bo;

    full_sub_cell u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (brw_q),
        .dif  (cell_d),
        .bout (cell_bo)
    );

    // Next-state: accept in IDLE, one bit per SHIFT cycle, publish in DONE
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dif_d   = dif_q;
        bout_d  = bout_q;
`ifdef SUB_FLAGS_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a_in;
                    b_sh_d  = bus.b_in;
                    brw_d   = bus.bin_in;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
`ifdef SUB_FLAGS_EN
                    a_msb_d = bus.a_in[WIDTH-1];
                    b_msb_d = bus.b_in[WIDTH-1];
`endif
                end
            end
            S_SHIFT: begin
                res_d  = {cell_d, res_q[WIDTH-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                brw_d  = cell_bo;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                dif_d   = res_q;
                bout_d  = brw_q;
                busy_d  = 1'b0;
                state_d = S_IDLE;
`ifdef SUB_FLAGS_EN
                zero_d  = (res_q == '0);
                ovf_d   = (a_msb_q != b_msb_q) &&
                          (res_q[WIDTH-1] != a_msb_q);
`endif
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs, synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dif_q   <= '0;
            bout_q  <= 1'b0;
`ifdef SUB_FLAGS_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dif_q   <= dif_d;
            bout_q  <= bout_d;
`ifdef SUB_FLAGS_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.dif_out = dif_q;
    assign bus.bout    = bout_q;
`ifdef SUB_FLAGS_EN
    assign bus.zero    = zero_q;
    assign bus.ovf     = ovf_q;
`endif
endmodule
